// File: rtl/seq_booth_mul.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | seq_booth_mul: multi-cycle radix-2 Booth multiplier, signed/unsigned    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module seq_booth_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   z
);

   localparam int             CW   = $clog2(WIDTH + 2);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [WIDTH:0]       mcand;
   logic [2*WIDTH+1:0]   acc;
   logic                 guard;
   logic [CW-1:0]        cnt;

   logic [WIDTH+1:0]     upper_ext;
   logic [WIDTH+1:0]     mcand_ext;
   logic [WIDTH+1:0]     sum;
   logic [2*WIDTH+1:0]   acc_next;
   logic                 guard_next;

   // One Booth step: add/sub at WIDTH+2 bits, then the extra sum bit
   // becomes the sign fill of the arithmetic right shift.
   always_comb begin
      upper_ext  = {acc[2*WIDTH+1], acc[2*WIDTH+1:WIDTH+1]};
      mcand_ext  = {mcand[WIDTH], mcand};
      case ({acc[0], guard})
         2'b01:   sum = upper_ext + mcand_ext;
         2'b10:   sum = upper_ext - mcand_ext;
         default: sum = upper_ext;
      endcase
      acc_next   = {sum, acc[WIDTH:1]};
      guard_next = acc[0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         z     <= '0;
         mcand <= '0;
         acc   <= '0;
         guard <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  mcand <= {is_signed & a[WIDTH-1], a};
                  acc   <= {{(WIDTH+1){1'b0}}, is_signed & b[WIDTH-1], b};
                  guard <= 1'b0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               acc   <= acc_next;
               guard <= guard_next;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
                  done  <= 1'b1;
                  z     <= acc_next[2*WIDTH-1:0];
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_booth_mul.sv
`default_nettype none
// Bench for seq_booth_mul: WIDTH=8 and WIDTH=16 instances, table vectors
// plus hand sequences, results checked through per-instance scoreboards.
module tb_seq_booth_mul;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sg;
      logic [31:0] z;
   } vec_t;

   typedef struct {
      logic [63:0] z;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        st8, sg8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] z8;
   logic        st16, sg16, busy16, done16;
   logic [15:0] a16, b16;
   logic [31:0] z16;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t q8[$];
   exp_t q16[$];
   vec_t tbl8[$];
   vec_t tbl16[$];
   logic prev8 = 1'b0;
   logic prev16 = 1'b0;

   seq_booth_mul #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(st8), .is_signed(sg8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .z(z8)
   );

   seq_booth_mul #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(st16), .is_signed(sg16),
      .a(a16), .b(b16), .busy(busy16), .done(done16), .z(z16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboards: every done pops one expectation (value and cycle).
   always @(negedge clk) begin
      exp_t e;
      if (done8 === 1'b1) begin
         if (prev8) chk("done8_consecutive", 1, 0);
         if (q8.size() == 0) chk("done8_unexpected", 1, 0);
         else begin
            e = q8.pop_front();
            chk("z8", {48'b0, z8}, e.z);
            chk("done8_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (done16 === 1'b1) begin
         if (prev16) chk("done16_consecutive", 1, 0);
         if (q16.size() == 0) chk("done16_unexpected", 1, 0);
         else begin
            e = q16.pop_front();
            chk("z16", {32'b0, z16}, e.z);
            chk("done16_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      prev8  = (done8 === 1'b1);
      prev16 = (done16 === 1'b1);
   end

   // Called at a falling edge; start is sampled on the next rising edge.
   task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                         input logic [15:0] ez, input bit track);
      a8 = av; b8 = bv; sg8 = sv; st8 = 1'b1;
      if (track) q8.push_back('{z: {48'b0, ez}, cyc: cyc + 1 + 9});
      @(negedge clk);
      st8 = 1'b0;
      chk("busy8_after_start", {63'b0, busy8}, 1);
   endtask

   task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          input logic [31:0] ez);
      a16 = av; b16 = bv; sg16 = sv; st16 = 1'b1;
      q16.push_back('{z: {32'b0, ez}, cyc: cyc + 1 + 17});
      @(negedge clk);
      st16 = 1'b0;
      chk("busy16_after_start", {63'b0, busy16}, 1);
   endtask

   task automatic drain(input int limit);
      for (int i = 0; i < limit && (q8.size() != 0 || q16.size() != 0); i++) @(negedge clk);
      if (q8.size() != 0 || q16.size() != 0) begin
         chk("done_timeout", 1, 0);
         q8.delete();
         q16.delete();
      end
   endtask

   task automatic wait_idle;
      for (int i = 0; i < 60 && (busy8 !== 1'b0 || busy16 !== 1'b0); i++) @(negedge clk);
      if (busy8 !== 1'b0 || busy16 !== 1'b0) chk("idle_timeout", 1, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  ra, rb;
      logic        rs;
      logic [15:0] rz;

      tbl8.push_back('{a: 16'hCC, b: 16'hE2, sg: 1'b0, z: 32'hB418});
      tbl8.push_back('{a: 16'hF0, b: 16'h0F, sg: 1'b0, z: 32'h0E10});
      tbl8.push_back('{a: 16'hAA, b: 16'h55, sg: 1'b0, z: 32'h3872});
      tbl8.push_back('{a: 16'hCC, b: 16'hE2, sg: 1'b1, z: 32'h0618});
      tbl8.push_back('{a: 16'hF0, b: 16'h0F, sg: 1'b1, z: 32'hFF10});
      tbl8.push_back('{a: 16'hAA, b: 16'h55, sg: 1'b1, z: 32'hE372});
      tbl8.push_back('{a: 16'h80, b: 16'h80, sg: 1'b1, z: 32'h4000});
      tbl8.push_back('{a: 16'hFF, b: 16'hFF, sg: 1'b1, z: 32'h0001});
      tbl8.push_back('{a: 16'hFF, b: 16'hFF, sg: 1'b0, z: 32'hFE01});
      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         // Low 16 bits of the product of the properly extended operands.
         if (rs) rz = {{8{ra[7]}}, ra} * {{8{rb[7]}}, rb};
         else    rz = {8'b0, ra} * {8'b0, rb};
         tbl8.push_back('{a: {8'b0, ra}, b: {8'b0, rb}, sg: rs, z: {16'b0, rz}});
      end
      tbl16.push_back('{a: 16'hFFFF, b: 16'hFFFF, sg: 1'b0, z: 32'hFFFE0001});
      tbl16.push_back('{a: 16'h8000, b: 16'h7FFF, sg: 1'b1, z: 32'hC0008000});

      // Reset held with start asserted.
      rst = 1'b0; st8 = 1'b1; st16 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; sg8 = 1'b0;
      a16 = 16'hFFFF; b16 = 16'hFFFF; sg16 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_busy8", {63'b0, busy8}, 0);
         chk("rst_done8", {63'b0, done8}, 0);
         chk("rst_z8", {48'b0, z8}, 0);
         chk("rst_busy16", {63'b0, busy16}, 0);
         chk("rst_z16", {32'b0, z16}, 0);
      end
      st8 = 1'b0; st16 = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("post_rst_busy8", {63'b0, busy8}, 0);

      foreach (tbl8[i]) begin
         wait_idle();
         issue8(tbl8[i].a[7:0], tbl8[i].b[7:0], tbl8[i].sg, tbl8[i].z[15:0], 1'b1);
         drain(30);
      end

      // Start pulses while busy must be ignored.
      wait_idle();
      issue8(8'h03, 8'h04, 1'b0, 16'h000C, 1'b1);
      for (int i = 0; i <= 10; i++) begin
         chk("busy8_profile", {63'b0, busy8}, (i <= 9) ? 64'd1 : 64'd0);
         a8 = 8'hFF; b8 = 8'hFF; sg8 = 1'b1;
         st8 = (i == 2 || i == 8);
         @(negedge clk);
      end
      chk("busy8_ignored_starts", 64'(q8.size()), 0);

      // Reset in the middle of a run: no done, result cleared.
      wait_idle();
      issue8(8'hCC, 8'hE2, 1'b0, 16'h0000, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("midrst_busy8", {63'b0, busy8}, 0);
      chk("midrst_z8", {48'b0, z8}, 0);
      chk("midrst_done8", {63'b0, done8}, 0);
      repeat (12) @(negedge clk);
      chk("midrst_still_idle", {63'b0, busy8}, 0);
      issue8(8'hCC, 8'hE2, 1'b0, 16'hB418, 1'b1);
      drain(30);

      foreach (tbl16[i]) begin
         wait_idle();
         issue16(tbl16[i].a, tbl16[i].b, tbl16[i].sg, tbl16[i].z);
         drain(40);
      end

      // Back-to-back at the minimum issue interval of WIDTH+3.
      wait_idle();
      issue16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
      repeat (18) @(negedge clk);
      chk("b2b_idle16", {63'b0, busy16}, 0);
      issue16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
      drain(40);
      chk("b2b_z16_held", {32'b0, z16}, 64'hC0008000);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_booth_mul.md
# seq_booth_mul

Parametrised, multi-cycle radix-2 Booth multiplier with a start/done handshake. It supports signed or unsigned operands, selected per operation. It replaces the fixed 8-bit combinational product units in the arithmetic datapath and trades latency for area. One operation is in flight at a time. The result is registered and held until the next operation completes or reset.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low; one clock, synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- a  input  WIDTH  multiplicand; captured with start.
- b  input  WIDTH  multiplier; captured with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  single-cycle pulse; z valid and updated in that cycle.
- z  output  2*WIDTH  product register; holds last result.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after WIDTH+1 iterations.
  - DONE -> IDLE unconditionally.
- Capture at the IDLE->RUN edge:
  - a and b extend to WIDTH+1 bits: sign-extended if is_signed=1, zero-extended if 0.
  - Accumulator of 2*WIDTH+2 bits loads with {WIDTH+1 zeros, extended b} plus a Booth guard bit q(-1)=0.
  - Iteration counter clears to 0.
- Each RUN cycle performs one iteration:
  - Examine {q0, q(-1)}: 01 adds extended a to the upper WIDTH+1 bits; 10 subtracts it; 00/11 does nothing.
  - Then arithmetic-shift the accumulator and guard right by 1.
  - Increment the counter.
- The upper add/subtract is performed at WIDTH+2 bits so no overflow is lost before the shift.
- At the final iteration, z loads with the low 2*WIDTH bits of the accumulator. The result is exact for both modes.
- start while busy=1 is ignored: no capture, no effect on the result. is_signed, a and b are don't-care outside the capture edge.
- z changes only at the RUN->DONE edge or on reset.
- Reset (rst=0 at a rising edge) takes effect from any state, including mid-RUN. The result is IDLE, busy=0, done=0, z=0, and counter/accumulator cleared. The aborted operation produces no done.
- rst=0 has priority over start in the same cycle.

## Timing
- Reset values: busy=0, done=0, z=0, state IDLE.
- Let start=1 be sampled in IDLE at edge k:
  - busy=1 from after edge k.
  - Iterations occur at edges k+1 .. k+WIDTH+1.
  - z updates and done=1 after edge k+WIDTH+1, for exactly one cycle.
  - busy is still 1 in DONE and falls after edge k+WIDTH+2.
- Latency from start edge to done: WIDTH+1 cycles.
- Issue interval: the next start is accepted at edge k+WIDTH+3 at the earliest, i.e. WIDTH+3 cycles between accepted starts.
- done never asserts in two consecutive cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst=0 for 2 cycles with start=1 -> busy=0, done=0, z=0x0000 throughout; no operation starts.
- WIDTH=8 unsigned, one operation per line:
  - 0xCC*0xE2 -> z=0xB418.
  - 0xF0*0x0F -> z=0x0E10.
  - 0xAA*0x55 -> z=0x3872.
  - For each, done pulses exactly 9 cycles after the start edge.
- WIDTH=8 signed, one operation per line:
  - 0xCC*0xE2 -> z=0x0618.
  - 0xF0*0x0F -> z=0xFF10.
  - 0xAA*0x55 -> z=0xE372.
  - 0x80*0x80 -> z=0x4000.
  - 0xFF*0xFF -> z=0x0001. For the same operands unsigned, z=0xFE01.
- Start while busy: start 0x03*0x04 unsigned, then pulse start with 0xFF*0xFF at cycles 3 and 9 after the start edge -> single done, z=0x000C, busy profile unchanged.
- Reset mid-operation: start 0xCC*0xE2 and drive rst=0 at cycle 4 -> next cycle busy=0, z=0x0000, no done. A new start after release yields the correct result on schedule.
- WIDTH=16, one operation per line:
  - unsigned 0xFFFF*0xFFFF -> z=0xFFFE0001.
  - signed 0x8000*0x7FFF -> z=0xC0008000.
  - Back-to-back starts at minimum issue interval (19 cycles) -> both done pulses correct, 19 cycles apart.
